// File: rtl/uwid_defs_pkg.sv
// Shared constants and state encoding for the serial pattern detector.
package uwid_defs_pkg;

   localparam int DEF_PAT_W = 4;
   localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0010;

   // FILL: fewer than PAT_W bits collected since reset/clear/restart.
   // ARMED: the window holds PAT_W valid bits and may be compared.
   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_ARMED = 1'b1
   } state_e;

endpackage

// File: rtl/uwid_shift_window.sv
// Serial shift window plus saturating fill counter. The fill count is the
// implicit FILL/ARMED state and is exposed through the state output.
//
// Handshake: a bit is consumed on every cycle with in_valid=1 and clear=0;
// there is no back-pressure. clear has priority and discards the bit.
module uwid_shift_window
   import uwid_defs_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear,
   input  logic             restart,
   output logic [PAT_W-1:0] window,
   output logic [PAT_W-1:0] next_window,
   output logic             fill_last,
   output state_e           state
);

   localparam int FW = $clog2(PAT_W + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);

   logic [FW-1:0]    fill;
   logic [FW-1:0]    fill_nxt;
   logic [PAT_W-1:0] window_nxt;

   // Shifted window value if this cycle's bit is taken; also used by the
   // comparator so a match is flagged on the same edge that shifts the bit in.
   assign next_window = (window << 1) | PAT_W'(in_bit);

   // Decoded state and "one bit short of full" for the match qualifier.
   assign state     = (fill == FULL) ? ST_ARMED : ST_FILL;
   assign fill_last = (fill == FULL - FW'(1));

   // State register: window and fill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         window <= '0;
         fill   <= '0;
      end else begin
         window <= window_nxt;
         fill   <= fill_nxt;
      end
   end

   // Next-state: clear wins, otherwise shift on valid; restart drops the
   // fill back to zero (non-overlapping mode) while the window keeps shifting.
   always_comb begin
      window_nxt = window;
      fill_nxt   = fill;
      if (clear) begin
         window_nxt = '0;
         fill_nxt   = '0;
      end else if (in_valid) begin
         window_nxt = next_window;
         if (restart) begin
            fill_nxt = '0;
         end else if (fill != FULL) begin
            fill_nxt = fill + FW'(1);
         end
      end
   end

endmodule

// File: rtl/uwid_seq_detector.sv
// Serial pattern detector: compares the incoming window against PATTERN,
// registers a one-cycle match pulse, counts matches (saturating) and keeps
// a sticky flag for the LED.
module uwid_seq_detector
   import uwid_defs_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   parameter int               CNT_W   = 8,
   parameter int               OVERLAP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear,
   output logic             match,
   output logic             match_seen,
   output logic [CNT_W-1:0] match_count,
   output logic [PAT_W-1:0] window
);

   logic [PAT_W-1:0] next_window;
   logic             fill_last;
   state_e           state;
   logic             next_full;
   logic             hit;
   logic             restart;

   uwid_shift_window #(
      .PAT_W (PAT_W)
   ) u_window (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .clear       (clear),
      .restart     (restart),
      .window      (window),
      .next_window (next_window),
      .fill_last   (fill_last),
      .state       (state)
   );

   // A match needs a consumed bit and a window that is full after the shift.
   assign next_full = (state == ST_ARMED) || fill_last;
   assign hit       = in_valid && !clear && next_full && (next_window == PATTERN);
   assign restart   = hit && (OVERLAP == 0);

   // Match pulse, saturating counter and sticky flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match       <= 1'b0;
         match_seen  <= 1'b0;
         match_count <= '0;
      end else if (clear) begin
         match       <= 1'b0;
         match_seen  <= 1'b0;
         match_count <= '0;
      end else begin
         match <= hit;
         if (hit) begin
            match_seen <= 1'b1;
            if (match_count != {CNT_W{1'b1}}) begin
               match_count <= match_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uwid_seq_detector.sv
// Bench for uwid_seq_detector: four parameterisations share one input
// stream and each is compared every cycle with its own reference model.
module tb_uwid_seq_detector;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_bit = 1'b0;
   logic clear = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   logic       a_match, a_seen; logic [7:0] a_cnt; logic [3:0] a_win;
   logic       b_match, b_seen; logic [7:0] b_cnt; logic [3:0] b_win;
   logic       c_match, c_seen; logic [1:0] c_cnt; logic [3:0] c_win;
   logic       d_match, d_seen; logic [7:0] d_cnt; logic [0:0] d_win;

   uwid_seq_detector #(.PAT_W(4), .PATTERN(4'b0010), .CNT_W(8), .OVERLAP(1)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match(a_match), .match_seen(a_seen), .match_count(a_cnt), .window(a_win));
   uwid_seq_detector #(.PAT_W(4), .PATTERN(4'b0010), .CNT_W(8), .OVERLAP(0)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match(b_match), .match_seen(b_seen), .match_count(b_cnt), .window(b_win));
   uwid_seq_detector #(.PAT_W(4), .PATTERN(4'b0010), .CNT_W(2), .OVERLAP(1)) dut_c (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match(c_match), .match_seen(c_seen), .match_count(c_cnt), .window(c_win));
   uwid_seq_detector #(.PAT_W(1), .PATTERN(1'b1), .CNT_W(8), .OVERLAP(1)) dut_d (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .match(d_match), .match_seen(d_seen), .match_count(d_cnt), .window(d_win));

   int o_match[4], o_seen[4], o_cnt[4], o_win[4];
   always_comb begin
      o_match = '{int'(a_match), int'(b_match), int'(c_match), int'(d_match)};
      o_seen  = '{int'(a_seen),  int'(b_seen),  int'(c_seen),  int'(d_seen)};
      o_cnt   = '{int'(a_cnt),   int'(b_cnt),   int'(c_cnt),   int'(d_cnt)};
      o_win   = '{int'(a_win),   int'(b_win),   int'(c_win),   int'(d_win)};
   end

   // ---------------- reference model ----------------
   // Per instance: pattern length, pattern, overlap mode, count ceiling.
   string nm[4]    = '{"ov", "nov", "sat", "w1"};
   int    pw[4]    = '{4, 4, 4, 1};
   int    pat[4]   = '{2, 2, 2, 1};
   int    ov[4]    = '{1, 0, 1, 1};
   int    cmax[4]  = '{255, 255, 3, 255};

   int m_win[4], m_bits[4], m_cnt[4], m_seen[4], m_match[4];

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_win[k] = 0; m_bits[k] = 0; m_cnt[k] = 0; m_seen[k] = 0; m_match[k] = 0;
      end
   endtask

   // m_bits counts bits collected toward a full pattern since the last
   // reset/clear (or since the last match in non-overlapping mode).
   task automatic model_update(input logic v, input logic b, input logic c);
      for (int k = 0; k < 4; k++) begin
         m_match[k] = 0;
         if (c) begin
            m_win[k] = 0; m_bits[k] = 0; m_cnt[k] = 0; m_seen[k] = 0;
         end else if (v) begin
            m_win[k] = ((m_win[k] * 2) + int'(b)) % (1 << pw[k]);
            m_bits[k] = m_bits[k] + 1;
            if (m_bits[k] >= pw[k] && m_win[k] == pat[k]) begin
               m_match[k] = 1;
               m_seen[k] = 1;
               if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
               if (ov[k] == 0) m_bits[k] = 0;
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string pfx);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_%s_match", pfx, nm[k]), o_match[k], m_match[k]);
         check($sformatf("%s_%s_seen",  pfx, nm[k]), o_seen[k],  m_seen[k]);
         check($sformatf("%s_%s_count", pfx, nm[k]), o_cnt[k],   m_cnt[k]);
         check($sformatf("%s_%s_window", pfx, nm[k]), o_win[k],  m_win[k]);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic v, input logic b, input logic c);
      @(negedge clk);
      in_valid = v; in_bit = b; clear = c;
      @(posedge clk);
      model_update(v, b, c);
      #1;
      check_all("cyc");
   endtask

   // Asynchronous reset raised between edges: outputs must drop at once.
   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("rst");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] bits, input int len, input int gap);
      for (int i = len - 1; i >= 0; i--) begin
         step(1'b1, bits[i], 1'b0);
         for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      do_reset();

      // Basic 0010.
      send_bits(16'b0010, 4, 0);
      check("basic_count", int'(a_cnt), 1);
      check("basic_seen", int'(a_seen), 1);
      step(1'b0, 1'b0, 1'b0);
      check("basic_pulse_end", int'(a_match), 0);

      // Overlap vs non-overlap on 0010010; stream is cut by a mid-stream reset first.
      send_bits(16'b001, 3, 0);
      do_reset();
      send_bits(16'b0010010, 7, 0);
      check("ovl_count", int'(a_cnt), 2);
      check("novl_count", int'(b_cnt), 1);

      // Gaps of three idle cycles between bits.
      do_reset();
      send_bits(16'b0010, 4, 3);
      check("gap_count", int'(a_cnt), 1);

      // Saturation on the 2-bit counter.
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         send_bits(16'b0010, 4, 0);
         check($sformatf("sat_count_%0d", i), int'(c_cnt), (i < 3) ? i : 3);
         check($sformatf("sat_pulse_%0d", i), int'(c_match), 1);
      end

      // Clear together with the completing bit.
      do_reset();
      send_bits(16'b0010, 4, 0);
      send_bits(16'b001, 3, 0);
      step(1'b1, 1'b0, 1'b1);
      check("clr_match", int'(a_match), 0);
      check("clr_count", int'(a_cnt), 0);
      check("clr_seen", int'(a_seen), 0);
      check("clr_window", int'(a_win), 0);
      send_bits(16'b0010, 4, 0);
      check("clr_rematch", int'(a_match), 1);

      // Random traffic with occasional clears and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
